// File: rtl/mem_pkg.sv
// Shared definitions for the CPU memory-bus arbiter: FSM encoding and bus widths.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INST = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory bus between instruction-fetch and data ports,
// with alternating priority on ties and a bus-timeout watchdog.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] o_data_i,
  output logic              o_ack_i,
  input  logic              i_rd_d,
  input  logic [BE_W-1:0]   i_wr_d,
  input  logic [ADDR_W-1:0] i_addr_d,
  input  logic [DATA_W-1:0] i_wdata_d,
  output logic [DATA_W-1:0] o_data_d,
  output logic              o_ack_d,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic [BE_W-1:0]   o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_bus_err
);

  // Handshake: a requester holds its request until it sees its one-cycle ack;
  // a request is ignored in its own ack cycle so the same access is never
  // granted twice. Memory holds ack for exactly one cycle per strobed access.

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  logic [1:0]        state;
  logic              last_d;
  logic [TW-1:0]     cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   wr_q;
  logic              rd_q;

  logic pend_i;
  logic pend_d;
  logic grant_i;
  logic grant_d;
  logic expire;
  logic is_data;

  always_comb begin
    pend_i  = i_req_i & ~o_ack_i;
    pend_d  = (i_rd_d | (|i_wr_d)) & ~o_ack_d;
    // On a tie the port that was not served last wins.
    grant_d = pend_d & (~pend_i | ~last_d);
    grant_i = pend_i & ~grant_d;
    expire  = ~i_mem_ack & (cnt == CNT_LAST);
    is_data = (state == ST_DATA);
  end

  // Strobes only exist while an access is in flight; everything else comes
  // straight from the grant-time latches so it stays stable for the access.
  always_comb begin
    o_mem_addr  = addr_q;
    o_mem_wdata = wdata_q;
    o_mem_rd    = (state == ST_INST) | (is_data & rd_q);
    o_mem_wr    = is_data ? wr_q : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      last_d    <= 1'b0;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= '0;
      rd_q      <= 1'b0;
      o_data_i  <= '0;
      o_data_d  <= '0;
      o_ack_i   <= 1'b0;
      o_ack_d   <= 1'b0;
      o_bus_err <= 1'b0;
    end else begin
      o_ack_i   <= 1'b0;
      o_ack_d   <= 1'b0;
      o_bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state   <= ST_DATA;
            addr_q  <= i_addr_d;
            wdata_q <= i_wdata_d;
            wr_q    <= i_wr_d;
            // A read combined with write enables is performed as a write only.
            rd_q    <= i_rd_d & ~(|i_wr_d);
            cnt     <= '0;
          end else if (grant_i) begin
            state   <= ST_INST;
            addr_q  <= i_addr_i;
            wdata_q <= '0;
            wr_q    <= '0;
            rd_q    <= 1'b1;
            cnt     <= '0;
          end
        end
        ST_INST, ST_DATA: begin
          if (i_mem_ack || expire) begin
            state     <= ST_IDLE;
            last_d    <= is_data;
            o_bus_err <= ~i_mem_ack;
            if (is_data) begin
              o_ack_d  <= 1'b1;
              o_data_d <= i_mem_ack ? i_mem_rdata : '0;
            end else begin
              o_ack_i  <= 1'b1;
              o_data_i <= i_mem_ack ? i_mem_rdata : '0;
            end
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
